timeclock_set_ctrl: RTL and testbench
=====================================

# timeclock_set_ctrl

Mode and time-setting controller for the FND time clock. It owns the hour/min/sec/msec time registers and runs them from a 100 Hz tick. A button-driven state machine lets the user set each field. It also drives the display page select and per-digit blanking, which are consumed by the digit dividers, the 4x1/2x1 display muxes and the font decoder. It replaces the free-running time counter and the raw mode switch.

## Interface
Parameters:
- BLINK_TICKS, 50, number of i_tick pulses per blink half-period (50 gives 0.5 s)

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge
- i_reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- i_tick  in  1  one-cycle pulse at 100 Hz (one msec-count step)
- i_btn_set  in  1  synchronized, debounced level; enters and exits set mode
- i_btn_next  in  1  synchronized, debounced level; selects the next field in set mode, toggles the page in RUN
- i_btn_up  in  1  synchronized, debounced level; increments the selected field
- o_hour  out  6  hours, 0..23
- o_min  out  6  minutes, 0..59
- o_sec  out  6  seconds, 0..59
- o_msec  out  7  hundredths, 0..99
- o_state  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
- o_disp_sel  out  1  1 = hour:min page, 0 = sec:msec page
- o_blank_digits  out  4  bit i = 1 blanks digit position i (position 0 = leftmost)

## Operation
- **Edge detection:** each button has a registered previous sample. An edge is `btn & ~prev`. Holding a button produces exactly one action.
- **Action priority:** if several edges occur in the same cycle, set wins over next, and next wins over up. Only one action is taken per cycle.
- **RUN:**
  - On i_tick, msec increments; 99 wraps to 0 and carries into sec.
  - sec 59 wraps to 0 and carries into min; min 59 wraps to 0 and carries into hour; hour 23 wraps to 0.
  - A next edge toggles the stored page preference; o_disp_sel follows it.
  - An up edge is ignored.
- **Entering set mode:** a set edge in RUN goes to SET_HOUR. msec clears to 0 and all ticks are ignored until RUN is re-entered.
- **Set states:**
  - An up edge increments the selected field with wrap (hour 23 to 0; min and sec 59 to 0). There is no carry into other fields.
  - A next edge steps SET_HOUR to SET_MIN, SET_MIN to SET_SEC, and SET_SEC back to SET_HOUR.
  - A set edge returns to RUN. Counting resumes from the set values with msec = 0.
- **Page select:**
  - SET_HOUR and SET_MIN force o_disp_sel = 1; SET_SEC forces o_disp_sel = 0.
  - In RUN, o_disp_sel equals the stored preference. The preference is unchanged by set mode.
- **Blink:**
  - A tick counter (0..BLINK_TICKS-1) and a phase bit run only in set states.
  - The phase toggles when the counter wraps.
  - The counter and phase clear to 0 on entry to any set state and on every up or next edge, so the field is visible immediately after each action.
- **Blanking:** o_blank_digits is 0000 in RUN and whenever the phase is 0. When the phase is 1:
  - SET_HOUR: 0011
  - SET_MIN: 1100
  - SET_SEC: 0011

## Timing
- **Reset values:** o_hour, o_min, o_sec and o_msec = 0; o_state = RUN; page preference = 1, so o_disp_sel = 1; o_blank_digits = 0000. Blink counter, phase and button previous samples = 0.
- **Reset release:** the first action can happen on the first rising edge after i_reset goes high. A button already held high at release counts as an edge.
- **Latency:** a tick or a button edge sampled at clock edge k is visible on the outputs after edge k. All outputs are registered or decoded directly from registers.
- **Tick plus button:** if a tick coincides with a set edge in RUN, the set edge wins and the tick is dropped. A tick coinciding with a next edge in RUN is applied, and the page also toggles.
- **Full rollover:** 23:59:59.99 plus one tick gives 00:00:00.00 in one cycle.
- **Reset during set mode:** asserting reset in a set state returns to RUN with cleared time, asynchronously.

## Test plan
- **Reset:** hold i_reset = 0, then release. Required: all time = 0, o_state = 00, o_disp_sel = 1, o_blank_digits = 0000.
- **Rollover:** preload to 23:59:59.99 via set mode (msec reaches 99 by ticks), then apply one tick. Required: 00:00:00.00, with the update visible the cycle after the tick.
- **Set sequence:**
  - Set edge, then 5 up edges: o_state = 01, hour = 5.
  - Next, then up x60: o_state = 10, min = 0 (wrapped).
  - Next, then up x3: o_state = 11, sec = 3, o_disp_sel = 0.
  - Set edge: o_state = 00, with 05:00:03.00 counting.
- **Freeze:** apply 200 ticks in SET_MIN. Required: time unchanged and msec = 0.
- **Blink:** enter SET_HOUR (BLINK_TICKS = 50).
  - o_blank_digits = 0000 for ticks 1-50 and 0011 after the 50th tick; it toggles every 50 ticks.
  - An up edge during the blank phase forces 0000 the next cycle.
- **Simultaneous edges and page toggle:**
  - Set, next and up rising in the same cycle in RUN: only the transition to SET_HOUR occurs, with hour unchanged.
  - A next edge in RUN toggles o_disp_sel 1 to 0. The value 0 persists after a full set/exit cycle.

Source files
------------

// File: rtl/timeclock_set_ctrl_if.sv
// Purpose : bundles the tick/button inputs and the time/display outputs of the
//           time clock set controller into one port.
// Ports   : i_tick, i_btn_set, i_btn_next, i_btn_up (to controller);
//           o_hour, o_min, o_sec, o_msec, o_state, o_disp_sel,
//           o_blank_digits (from controller).
//           The master modport drives the inputs; the slave modport is the controller.
interface timeclock_set_ctrl_if;
  logic       i_tick;
  logic       i_btn_set;
  logic       i_btn_next;
  logic       i_btn_up;
  logic [5:0] o_hour;
  logic [5:0] o_min;
  logic [5:0] o_sec;
  logic [6:0] o_msec;
  logic [1:0] o_state;
  logic       o_disp_sel;
  logic [3:0] o_blank_digits;

  modport master (
    output i_tick, i_btn_set, i_btn_next, i_btn_up,
    input  o_hour, o_min, o_sec, o_msec, o_state, o_disp_sel, o_blank_digits
  );

  modport slave (
    input  i_tick, i_btn_set, i_btn_next, i_btn_up,
    output o_hour, o_min, o_sec, o_msec, o_state, o_disp_sel, o_blank_digits
  );
endinterface

// File: rtl/timeclock_set_ctrl.sv
// Purpose     : time registers (hh:mm:ss.cc) run from a 100 Hz tick, plus a
//               button-driven set mode with field blink and display page select.
// Latency     : a tick or button edge sampled at edge k shows on the outputs after edge k.
// Backpressure: none; every tick and button edge is consumed in the cycle it arrives.
// Ports       : i_clk, i_reset (async, active-low), bus (slave modport of
//               timeclock_set_ctrl_if carrying tick, buttons and all outputs).
module timeclock_set_ctrl #(
  parameter int BLINK_TICKS = 50
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  timeclock_set_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [5:0]    hour;
  logic [5:0]    min;
  logic [5:0]    sec;
  logic [6:0]    msec;
  logic          page_pref;
  logic [CW-1:0] blink_cnt;
  logic          blink_phase;
  logic          prev_set;
  logic          prev_next;
  logic          prev_up;
  logic          disp_sel;
  logic [3:0]    blank;

  // Rising-edge detection against the previous sample; prev resets to 0 so a
  // button already held at reset release counts as an edge.
  logic edge_set, edge_next, edge_up;
  assign edge_set  = bus.i_btn_set  & ~prev_set;
  assign edge_next = bus.i_btn_next & ~prev_next;
  assign edge_up   = bus.i_btn_up   & ~prev_up;

  // One action per cycle: set beats next, next beats up.
  logic act_set, act_next, act_up;
  assign act_set  = edge_set;
  assign act_next = edge_next & ~edge_set;
  assign act_up   = edge_up & ~edge_next & ~edge_set;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      prev_set  <= 1'b0;
      prev_next <= 1'b0;
      prev_up   <= 1'b0;
    end else begin
      prev_set  <= bus.i_btn_set;
      prev_next <= bus.i_btn_next;
      prev_up   <= bus.i_btn_up;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    disp_sel  = page_pref;
    blank     = 4'b0000;
    case (state)
      RUN: begin
        if (act_set) state_nxt = SET_HOUR;
      end
      SET_HOUR: begin
        disp_sel = 1'b1;
        if (blink_phase) blank = 4'b0011;
        if (act_set)       state_nxt = RUN;
        else if (act_next) state_nxt = SET_MIN;
      end
      SET_MIN: begin
        disp_sel = 1'b1;
        if (blink_phase) blank = 4'b1100;
        if (act_set)       state_nxt = RUN;
        else if (act_next) state_nxt = SET_SEC;
      end
      SET_SEC: begin
        disp_sel = 1'b0;
        if (blink_phase) blank = 4'b0011;
        if (act_set)       state_nxt = RUN;
        else if (act_next) state_nxt = SET_HOUR;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Time registers. In RUN a set edge drops any coincident tick and zeroes
  // msec; msec then stays 0 because ticks are ignored in set states.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      hour <= 6'd0;
      min  <= 6'd0;
      sec  <= 6'd0;
      msec <= 7'd0;
    end else if (state == RUN) begin
      if (act_set) begin
        msec <= 7'd0;
      end else if (bus.i_tick) begin
        if (msec == 7'd99) begin
          msec <= 7'd0;
          if (sec == 6'd59) begin
            sec <= 6'd0;
            if (min == 6'd59) begin
              min  <= 6'd0;
              hour <= (hour == 6'd23) ? 6'd0 : hour + 6'd1;
            end else begin
              min <= min + 6'd1;
            end
          end else begin
            sec <= sec + 6'd1;
          end
        end else begin
          msec <= msec + 7'd1;
        end
      end
    end else if (act_up) begin
      case (state)
        SET_HOUR: hour <= (hour == 6'd23) ? 6'd0 : hour + 6'd1;
        SET_MIN:  min  <= (min  == 6'd59) ? 6'd0 : min  + 6'd1;
        SET_SEC:  sec  <= (sec  == 6'd59) ? 6'd0 : sec  + 6'd1;
        default:  ;
      endcase
    end
  end

  // Page preference only changes on a next edge in RUN; set mode forces the
  // page through the decode above without touching it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                  page_pref <= 1'b1;
    else if (state == RUN && act_next) page_pref <= ~page_pref;
  end

  // Blink timer is held clear in RUN and restarted by every action, so a
  // freshly entered or edited field is shown for a full half-period.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (state == RUN || act_set || act_next || act_up) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.i_tick) begin
      if (blink_cnt == CW'(BLINK_TICKS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign bus.o_hour         = hour;
  assign bus.o_min          = min;
  assign bus.o_sec          = sec;
  assign bus.o_msec         = msec;
  assign bus.o_state        = state;
  assign bus.o_disp_sel     = disp_sel;
  assign bus.o_blank_digits = blank;

endmodule

// File: tb/tb_timeclock_set_ctrl.sv
// Purpose : directed, self-checking bench for timeclock_set_ctrl.
// Ports   : none; drives the DUT through a timeclock_set_ctrl_if instance.
module tb_timeclock_set_ctrl;

  localparam int OP_TICK = 0;
  localparam int OP_SET  = 1;
  localparam int OP_NEXT = 2;
  localparam int OP_UP   = 3;

  typedef struct {
    int op;
    int n;
    int hour;
    int min;
    int sec;
    int msec;
    int state;
    int disp;
    int blank;
  } vec_t;

  logic i_clk;
  logic i_reset;
  timeclock_set_ctrl_if bus ();

  timeclock_set_ctrl #(.BLINK_TICKS(50)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int h, input int m, input int s,
                         input int ms, input int st, input int d, input int b);
    chk({tag, ".hour"},  int'(bus.o_hour), h);
    chk({tag, ".min"},   int'(bus.o_min), m);
    chk({tag, ".sec"},   int'(bus.o_sec), s);
    chk({tag, ".msec"},  int'(bus.o_msec), ms);
    chk({tag, ".state"}, int'(bus.o_state), st);
    chk({tag, ".disp"},  int'(bus.o_disp_sel), d);
    chk({tag, ".blank"}, int'(bus.o_blank_digits), b);
  endtask

  // One clock with the given inputs; returns 1 ns after the rising edge.
  task automatic cyc(input logic t, input logic s, input logic n, input logic u);
    bus.i_tick     = t;
    bus.i_btn_set  = s;
    bus.i_btn_next = n;
    bus.i_btn_up   = u;
    @(posedge i_clk);
    #1;
  endtask

  task automatic press(input int op);
    cyc(1'b0, op == OP_SET, op == OP_NEXT, op == OP_UP);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bus.i_tick = 1'b0;
  endtask

  task automatic presses(input int op, input int n);
    repeat (n) press(op);
  endtask

  initial begin
    //           op       n    h  m  s  ms st d  blank
    tbl[0]  = '{OP_TICK,  3,   0, 0, 0, 3, 0, 1, 0};
    tbl[1]  = '{OP_NEXT,  1,   0, 0, 0, 3, 0, 0, 0};
    tbl[2]  = '{OP_NEXT,  1,   0, 0, 0, 3, 0, 1, 0};
    tbl[3]  = '{OP_SET,   1,   0, 0, 0, 0, 1, 1, 0};
    tbl[4]  = '{OP_UP,    5,   5, 0, 0, 0, 1, 1, 0};
    tbl[5]  = '{OP_NEXT,  1,   5, 0, 0, 0, 2, 1, 0};
    tbl[6]  = '{OP_UP,   60,   5, 0, 0, 0, 2, 1, 0};
    tbl[7]  = '{OP_TICK, 200,  5, 0, 0, 0, 2, 1, 0};
    tbl[8]  = '{OP_TICK, 50,   5, 0, 0, 0, 2, 1, 12};
    tbl[9]  = '{OP_NEXT,  1,   5, 0, 0, 0, 3, 0, 0};
    tbl[10] = '{OP_UP,    3,   5, 0, 3, 0, 3, 0, 0};
    tbl[11] = '{OP_TICK, 50,   5, 0, 3, 0, 3, 0, 3};
    tbl[12] = '{OP_SET,   1,   5, 0, 3, 0, 0, 1, 0};
    tbl[13] = '{OP_TICK,  7,   5, 0, 3, 7, 0, 1, 0};

    bus.i_tick = 1'b0;
    bus.i_btn_set = 1'b0;
    bus.i_btn_next = 1'b0;
    bus.i_btn_up = 1'b0;
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 1, 0);
    i_reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("post_release", 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 14; i++) begin
      case (tbl[i].op)
        OP_TICK: ticks(tbl[i].n);
        default: presses(tbl[i].op, tbl[i].n);
      endcase
      chk_all($sformatf("vec%0d", i), tbl[i].hour, tbl[i].min, tbl[i].sec,
              tbl[i].msec, tbl[i].state, tbl[i].disp, tbl[i].blank);
    end

    // Blink cadence in SET_HOUR and restart by an up edge; holding up acts once.
    press(OP_SET);
    chk_all("blink_enter", 5, 0, 3, 0, 1, 1, 0);
    ticks(49);
    chk("blink_t49", int'(bus.o_blank_digits), 0);
    ticks(1);
    chk("blink_t50", int'(bus.o_blank_digits), 3);
    ticks(49);
    chk("blink_t99", int'(bus.o_blank_digits), 3);
    ticks(1);
    chk("blink_t100", int'(bus.o_blank_digits), 0);
    ticks(50);
    chk("blink_t150", int'(bus.o_blank_digits), 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("blink_up_unblank", int'(bus.o_blank_digits), 0);
    chk("blink_up_hour", int'(bus.o_hour), 6);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold_up_once", int'(bus.o_hour), 6);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    press(OP_SET);
    chk_all("blink_exit", 6, 0, 3, 0, 0, 1, 0);

    // Full rollover from 23:59:59.99.
    press(OP_SET);
    presses(OP_UP, 17);
    press(OP_NEXT);
    presses(OP_UP, 59);
    press(OP_NEXT);
    presses(OP_UP, 56);
    press(OP_SET);
    chk_all("preload", 23, 59, 59, 0, 0, 1, 0);
    ticks(99);
    chk_all("pre_roll", 23, 59, 59, 99, 0, 1, 0);
    ticks(1);
    chk_all("rollover", 0, 0, 0, 0, 0, 1, 0);

    // Set, next and up together: only the set action happens.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk_all("simul", 0, 0, 0, 0, 1, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    press(OP_SET);
    chk_all("simul_exit", 0, 0, 0, 0, 0, 1, 0);

    // Tick with set in RUN: tick dropped.
    ticks(5);
    chk("pre_tickset_msec", int'(bus.o_msec), 5);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("tick_set", 0, 0, 0, 0, 1, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    press(OP_SET);
    chk_all("tick_set_exit", 0, 0, 0, 0, 0, 1, 0);

    // Tick with next in RUN: both applied; page preference survives set mode.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("tick_next", 0, 0, 0, 1, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    press(OP_SET);
    chk_all("pref_set_hour", 0, 0, 0, 0, 1, 1, 0);
    press(OP_NEXT);
    chk_all("pref_set_min", 0, 0, 0, 0, 2, 1, 0);
    press(OP_NEXT);
    chk_all("pref_set_sec", 0, 0, 0, 0, 3, 0, 0);
    press(OP_NEXT);
    chk("next_wrap_state", int'(bus.o_state), 1);
    press(OP_SET);
    chk_all("pref_kept", 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset while in set mode, then release with set held.
    press(OP_SET);
    presses(OP_UP, 2);
    chk("pre_reset_hour", int'(bus.o_hour), 2);
    #3;
    i_reset = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 1, 0);
    bus.i_btn_set = 1'b1;
    #2;
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    chk("held_at_release", int'(bus.o_state), 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("held_no_repeat", int'(bus.o_state), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
